// File: rtl/ps2_move_decoder_if.sv
// Byte-in / direction-out bundle between the PS/2 receiver, the decoder and the
// square-movement logic. master = byte producer side, slave = decoder side.
interface ps2_move_decoder_if;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       move_up;
  logic       move_down;
  logic       move_left;
  logic       move_right;
  logic [7:0] held_keys;
  logic       key_event;

  modport master (
    output ps2_key_data, ps2_key_pressed,
    input  move_up, move_down, move_left, move_right, held_keys, key_event
  );

  modport slave (
    input  ps2_key_data, ps2_key_pressed,
    output move_up, move_down, move_left, move_right, held_keys, key_event
  );
endinterface

// File: rtl/ps2_move_decoder.sv
// PS/2 set-2 byte stream to held arrow/WASD levels with opposing-key cancel and
// a stuck-key watchdog that drops all held keys after a silent period.
module ps2_move_decoder #(
  parameter int unsigned STUCK_TIMEOUT = 25000000,
  parameter int unsigned CNT_W         = 25
) (
  input logic               clock,
  input logic               reset,
  ps2_move_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [7:0]       held_q, held_d;
  logic             event_q, event_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       apply;
  logic       is_make;
  logic       is_ext;
  logic       wd_expire;
  logic [7:0] key_mask;

  // Held-bit order is {D,A,S,W,right,left,down,up}; the E0 flag must match the map.
  function automatic logic [7:0] map_key(input logic ext, input logic [7:0] code);
    logic [7:0] m;
    m = 8'h00;
    if (ext) begin
      case (code)
        8'h75:   m = 8'h01;
        8'h72:   m = 8'h02;
        8'h6B:   m = 8'h04;
        8'h74:   m = 8'h08;
        default: m = 8'h00;
      endcase
    end else begin
      case (code)
        8'h1D:   m = 8'h10;
        8'h1B:   m = 8'h20;
        8'h1C:   m = 8'h40;
        8'h23:   m = 8'h80;
        default: m = 8'h00;
      endcase
    end
    return m;
  endfunction

  assign wd_expire = (STUCK_TIMEOUT != 0) && (held_q != 8'h00) &&
                     (cnt_q == CNT_W'(STUCK_TIMEOUT));

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    held_d   = held_q;
    cnt_d    = cnt_q;
    apply    = 1'b0;
    is_make  = 1'b0;
    is_ext   = 1'b0;
    key_mask = 8'h00;

    if (bus.ps2_key_pressed) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          case (bus.ps2_key_data)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = PAUSE;
              skip_d  = 3'd7;
            end
            8'hAA, 8'hFC, 8'h00, 8'hFF: held_d = 8'h00;
            8'hFA, 8'hFE, 8'hEE: ;
            default: begin
              apply   = 1'b1;
              is_make = 1'b1;
            end
          endcase
        end
        EXT: begin
          if (bus.ps2_key_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (bus.ps2_key_data != 8'hE0) begin
            apply   = 1'b1;
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          if (bus.ps2_key_data != 8'hF0) begin
            apply   = 1'b1;
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          if (bus.ps2_key_data != 8'hF0) begin
            apply   = 1'b1;
            is_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        PAUSE: begin
          // The pause key sends E1 plus seven more bytes and never breaks.
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      key_mask = map_key(is_ext, bus.ps2_key_data);
      if (apply) begin
        held_d = is_make ? (held_q | key_mask) : (held_q & ~key_mask);
      end
    end else if (wd_expire) begin
      held_d = 8'h00;
      cnt_d  = '0;
    end else if (held_q == 8'h00 || STUCK_TIMEOUT == 0) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STUCK_TIMEOUT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    event_d = (held_d != held_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      skip_q  <= 3'd0;
      held_q  <= 8'h00;
      event_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      held_q  <= held_d;
      event_q <= event_d;
      cnt_q   <= cnt_d;
    end
  end

  logic up_req, down_req, left_req, right_req;
  assign up_req    = held_q[0] | held_q[4];
  assign down_req  = held_q[1] | held_q[5];
  assign left_req  = held_q[2] | held_q[6];
  assign right_req = held_q[3] | held_q[7];

  assign bus.move_up    = up_req & ~down_req;
  assign bus.move_down  = down_req & ~up_req;
  assign bus.move_left  = left_req & ~right_req;
  assign bus.move_right = right_req & ~left_req;
  assign bus.held_keys  = held_q;
  assign bus.key_event  = event_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench: decoder with a short watchdog (dut_a) and one with the
// watchdog disabled (dut_b), both fed the same byte stream.
module tb_ps2_move_decoder;
  logic clock;
  logic reset;
  int   n_vec;
  int   n_bad;
  int   ev_a;
  int   ev_b;
  int   ev0;

  ps2_move_decoder_if bus_a ();
  ps2_move_decoder_if bus_b ();

  assign bus_b.ps2_key_data    = bus_a.ps2_key_data;
  assign bus_b.ps2_key_pressed = bus_a.ps2_key_pressed;

  ps2_move_decoder #(.STUCK_TIMEOUT(100), .CNT_W(7)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  ps2_move_decoder #(.STUCK_TIMEOUT(0), .CNT_W(25)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // key_event is sampled at the edge after it was raised, so counts lag by one edge.
  always @(posedge clock) begin
    if (bus_a.key_event === 1'b1) ev_a++;
    if (bus_b.key_event === 1'b1) ev_b++;
  end

  task automatic put(input logic [7:0] b);
    bus_a.ps2_key_data    = b;
    bus_a.ps2_key_pressed = 1'b1;
    @(negedge clock);
    bus_a.ps2_key_pressed = 1'b0;
    $display("byte %02h -> held_a=%02h ev=%0b held_b=%02h", b, bus_a.held_keys,
             bus_a.key_event, bus_b.held_keys);
  endtask

  task automatic settle();
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.ps2_key_pressed = 1'b0;
    bus_a.ps2_key_data    = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (bus_a.held_keys !== 8'h00 || bus_a.key_event !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state held=%02h ev=%0b want 00/0", bus_a.held_keys, bus_a.key_event);
    end
    n_vec++;
    if ({bus_a.move_up, bus_a.move_down, bus_a.move_left, bus_a.move_right} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_moves got %b want 0000",
               {bus_a.move_up, bus_a.move_down, bus_a.move_left, bus_a.move_right});
    end
  endtask

  task automatic test_arrow();
    ev0 = ev_a;
    put(8'hE0); put(8'h75);
    n_vec++;
    if (bus_a.held_keys !== 8'h01 || bus_a.move_up !== 1'b1 || bus_a.key_event !== 1'b1) begin
      n_bad++;
      $display("FAIL arrow_make held=%02h up=%0b ev=%0b want 01/1/1",
               bus_a.held_keys, bus_a.move_up, bus_a.key_event);
    end
    put(8'hE0); put(8'hF0); put(8'h75);
    settle();
    n_vec++;
    if (bus_a.held_keys !== 8'h00 || bus_a.move_up !== 1'b0 || ev_a - ev0 !== 2) begin
      n_bad++;
      $display("FAIL arrow_break held=%02h up=%0b events=%0d want 00/0/2",
               bus_a.held_keys, bus_a.move_up, ev_a - ev0);
    end
  endtask

  task automatic test_wasd_opposing();
    put(8'h1D);
    n_vec++;
    if (bus_a.held_keys !== 8'h10 || bus_a.move_up !== 1'b1) begin
      n_bad++;
      $display("FAIL wasd_w held=%02h up=%0b want 10/1", bus_a.held_keys, bus_a.move_up);
    end
    put(8'hE0); put(8'h72);
    n_vec++;
    if (bus_a.held_keys !== 8'h12 || bus_a.move_up !== 1'b0 || bus_a.move_down !== 1'b0) begin
      n_bad++;
      $display("FAIL opposing held=%02h up=%0b dn=%0b want 12/0/0",
               bus_a.held_keys, bus_a.move_up, bus_a.move_down);
    end
    settle();
    ev0 = ev_a;
    put(8'hE0); put(8'hF0); put(8'h75);
    settle();
    n_vec++;
    if (bus_a.held_keys !== 8'h12 || ev_a != ev0 || bus_a.move_up !== 1'b0 || bus_a.move_down !== 1'b0) begin
      n_bad++;
      $display("FAIL unheld_break held=%02h events=%0d up=%0b dn=%0b want 12/0/0/0",
               bus_a.held_keys, ev_a - ev0, bus_a.move_up, bus_a.move_down);
    end
    put(8'hF0); put(8'h1D);
    n_vec++;
    if (bus_a.held_keys !== 8'h02 || bus_a.move_down !== 1'b1 || bus_a.move_up !== 1'b0) begin
      n_bad++;
      $display("FAIL w_release held=%02h dn=%0b up=%0b want 02/1/0",
               bus_a.held_keys, bus_a.move_down, bus_a.move_up);
    end
    put(8'hE0); put(8'hF0); put(8'h72);
  endtask

  task automatic test_ext_mismatch_repeat();
    put(8'hE0); put(8'h6B);
    put(8'hF0); put(8'h6B);
    n_vec++;
    if (bus_a.held_keys !== 8'h04 || bus_a.move_left !== 1'b1) begin
      n_bad++;
      $display("FAIL keypad_break held=%02h left=%0b want 04/1", bus_a.held_keys, bus_a.move_left);
    end
    settle();
    ev0 = ev_a;
    for (int i = 0; i < 3; i++) begin
      put(8'hE0); put(8'h6B);
    end
    settle();
    n_vec++;
    if (ev_a != ev0 || bus_a.held_keys !== 8'h04) begin
      n_bad++;
      $display("FAIL typematic events=%0d held=%02h want 0/04", ev_a - ev0, bus_a.held_keys);
    end
    put(8'hE0); put(8'h1D);
    n_vec++;
    if (bus_a.held_keys !== 8'h04) begin
      n_bad++;
      $display("FAIL ext_wasd_unmapped held=%02h want 04", bus_a.held_keys);
    end
    put(8'hE0); put(8'hF0); put(8'h6B);
  endtask

  task automatic test_pause_and_bat();
    put(8'h1D);
    settle();
    ev0 = ev_a;
    put(8'hE1); put(8'h14); put(8'h77); put(8'hE1);
    put(8'hF0); put(8'h14); put(8'hF0); put(8'h77);
    settle();
    n_vec++;
    if (bus_a.held_keys !== 8'h10 || ev_a != ev0) begin
      n_bad++;
      $display("FAIL pause_seq held=%02h events=%0d want 10/0", bus_a.held_keys, ev_a - ev0);
    end
    put(8'h23);
    n_vec++;
    if (bus_a.held_keys !== 8'h90 || bus_a.move_right !== 1'b1 || bus_a.move_up !== 1'b1) begin
      n_bad++;
      $display("FAIL after_pause held=%02h right=%0b up=%0b want 90/1/1",
               bus_a.held_keys, bus_a.move_right, bus_a.move_up);
    end
    put(8'hAA);
    n_vec++;
    if (bus_a.held_keys !== 8'h00 || bus_a.key_event !== 1'b1) begin
      n_bad++;
      $display("FAIL bat_clear held=%02h ev=%0b want 00/1", bus_a.held_keys, bus_a.key_event);
    end
    put(8'hFA);
    n_vec++;
    if (bus_a.held_keys !== 8'h00 || bus_a.key_event !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_ignored held=%02h ev=%0b want 00/0", bus_a.held_keys, bus_a.key_event);
    end
  endtask

  task automatic test_back_to_back();
    bus_a.ps2_key_data    = 8'hE0;
    bus_a.ps2_key_pressed = 1'b1;
    @(negedge clock);
    bus_a.ps2_key_data    = 8'h74;
    @(negedge clock);
    bus_a.ps2_key_data    = 8'h1C;
    @(negedge clock);
    bus_a.ps2_key_pressed = 1'b0;
    $display("burst E0 74 1C -> held_a=%02h", bus_a.held_keys);
    n_vec++;
    if (bus_a.held_keys !== 8'h48 || bus_a.move_left !== 1'b0 || bus_a.move_right !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_back held=%02h left=%0b right=%0b want 48/0/0",
               bus_a.held_keys, bus_a.move_left, bus_a.move_right);
    end
    put(8'hF0); put(8'h1C);
    put(8'hE0); put(8'hF0); put(8'h74);
    n_vec++;
    if (bus_a.held_keys !== 8'h00) begin
      n_bad++;
      $display("FAIL burst_release held=%02h want 00", bus_a.held_keys);
    end
  endtask

  task automatic test_reset_mid_sequence();
    put(8'hE0); put(8'h75);
    put(8'hE0); put(8'hF0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++;
    if (bus_a.held_keys !== 8'h00 || bus_a.key_event !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid held=%02h ev=%0b want 00/0", bus_a.held_keys, bus_a.key_event);
    end
    reset = 1'b0;
    @(negedge clock);
    put(8'h75);
    n_vec++;
    if (bus_a.held_keys !== 8'h00 || bus_a.move_up !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_abandon held=%02h up=%0b want 00/0", bus_a.held_keys, bus_a.move_up);
    end
  endtask

  task automatic test_watchdog();
    put(8'hE0); put(8'h74);
    repeat (100) @(negedge clock);
    n_vec++;
    if (bus_a.held_keys !== 8'h08) begin
      n_bad++;
      $display("FAIL wd_early held=%02h want 08", bus_a.held_keys);
    end
    @(negedge clock);
    n_vec++;
    if (bus_a.held_keys !== 8'h00 || bus_a.key_event !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_expire held=%02h ev=%0b want 00/1", bus_a.held_keys, bus_a.key_event);
    end
    @(negedge clock);
    n_vec++;
    if (bus_a.key_event !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_single_pulse ev=%0b want 0", bus_a.key_event);
    end
    ev0 = ev_b;
    repeat (10000) @(negedge clock);
    n_vec++;
    if (bus_b.held_keys !== 8'h08 || ev_b != ev0) begin
      n_bad++;
      $display("FAIL wd_disabled held=%02h events=%0d want 08/0", bus_b.held_keys, ev_b - ev0);
    end
    put(8'hE0); put(8'hF0); put(8'h74);
    n_vec++;
    if (bus_b.held_keys !== 8'h00 || bus_a.held_keys !== 8'h00) begin
      n_bad++;
      $display("FAIL wd_cleanup held_b=%02h held_a=%02h want 00/00", bus_b.held_keys, bus_a.held_keys);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    ev_a  = 0;
    ev_b  = 0;
    ev0   = 0;
    reset = 1'b1;
    bus_a.ps2_key_data    = 8'h00;
    bus_a.ps2_key_pressed = 1'b0;
    test_reset();
    test_arrow();
    test_wasd_opposing();
    test_ext_mismatch_repeat();
    test_pause_and_bat();
    test_back_to_back();
    test_reset_mid_sequence();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
